uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 100 ++++++++++
 tb/tb_uart_tx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: FIFO-fed 8N1 serial transmitter; define UART_TX_PARITY_EN for an even-parity bit (8E1)
module uart_tx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_enable,
  input  logic       fifo_empty,
  input  logic       data_valid,
  input  logic [7:0] data_in,
  output logic       read_en,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_DATA, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0] idx, idx_n;
  logic [1:0] wcnt, wcnt_n;
  logic [7:0] sreg, sreg_n;
  logic tx_n, armed, bit_end;
  assign bit_end = baud == BW'(CLKS_PER_BIT - 1);
  assign read_en = state == FETCH;
  assign tx_busy = state != IDLE;
  assign tx_done = state == STOP && bit_end;
  // armed holds off the first fetch for one edge after reset release so a FIFO pop never races the release
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      baud  <= '0;
      idx   <= '0;
      wcnt  <= '0;
      sreg  <= '0;
      tx    <= 1'b1;
      armed <= 1'b0;
    end else begin
      state <= state_n;
      baud  <= baud_n;
      idx   <= idx_n;
      wcnt  <= wcnt_n;
      sreg  <= sreg_n;
      tx    <= tx_n;
      armed <= 1'b1;
    end
  // next state and the registered line level for the state being entered
  always_comb begin
    state_n = state;
    baud_n  = (state inside {START, DATA, PARITY, STOP}) && !bit_end ? baud + BW'(1) : '0;
    idx_n   = idx;
    wcnt_n  = '0;
    sreg_n  = sreg;
    tx_n    = tx;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (armed && tx_enable && !fifo_empty) state_n = FETCH;
      end
      FETCH: state_n = WAIT_DATA;
      WAIT_DATA:
        if (data_valid) begin
          sreg_n  = data_in;
          state_n = START;
          tx_n    = 1'b0;
        end else if (wcnt == 2'd3) state_n = IDLE;
        else wcnt_n = wcnt + 2'd1;
      START:
        if (bit_end) begin
          state_n = DATA;
          idx_n   = '0;
          tx_n    = sreg[0];
        end
      DATA:
        if (bit_end) begin
          idx_n = idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = ^sreg;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else tx_n = sreg[idx + 3'd1];
        end
      PARITY:
        if (bit_end) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end
      STOP:
        if (bit_end) begin
          state_n = IDLE;
          tx_n    = 1'b1;
        end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx with a FIFO model and a serial-line frame monitor
module tb_uart_tx;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int NB = 10;
  localparam bit PAR = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0, tx_enable = 1'b0;
  logic fifo_empty = 1'b1, data_valid = 1'b0;
  logic [7:0] data_in = '0;
  logic read_en, tx, tx_busy, tx_done;
  logic hold_dv = 1'b0;
  int checks = 0, failures = 0;
  int rd_cnt = 0, done_cnt = 0, busy_cnt = 0, low_cnt = 0, cyc = 0, last_done = -1000;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int gap_q[$];
  bit in_frame = 1'b0;
  int pos = 0, bad = 0;
  logic [10:0] ebits, gbits;
  logic [7:0] exp_b;

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset_n(reset_n), .tx_enable(tx_enable), .fifo_empty(fifo_empty),
    .data_valid(data_valid), .data_in(data_in), .read_en(read_en), .tx(tx),
    .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: pop on read_en, present data one cycle later unless hold_dv withholds the strobe
  always @(posedge clk) begin
    data_valid <= 1'b0;
    if (read_en && fifo_q.size() > 0) begin
      data_in <= fifo_q.pop_front();
      data_valid <= !hold_dv;
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  // line monitor: event counters plus cycle-exact frame check against the scoreboard
  always @(negedge clk) begin
    if (!reset_n) in_frame = 1'b0;
    else begin
      if (tx_busy) busy_cnt++;
      if (read_en) rd_cnt++;
      if (tx === 1'b0) low_cnt++;
      if (tx_done) begin done_cnt++; last_done = cyc; end
      if (!in_frame && tx === 1'b0) begin
        in_frame = 1'b1; pos = 0; bad = 0;
        gap_q.push_back(cyc - last_done - 1);
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_frame: line started a frame with nothing queued");
          exp_b = 8'h00;
        end else exp_b = exp_q.pop_front();
        ebits = {1'b1, PAR ? ^exp_b : 1'b1, exp_b, 1'b0};
      end
      if (in_frame) begin
        if (tx !== ebits[pos / CPB] || tx_done !== (pos == NB * CPB - 1)) bad++;
        if (pos % CPB == CPB / 2) gbits[pos / CPB] = tx;
        pos++;
        if (pos == NB * CPB) begin
          in_frame = 1'b0;
          checks++;
          if (gbits[8:1] !== exp_b) begin
            failures++;
            $display("FAIL frame_data: got=%02h exp=%02h", gbits[8:1], exp_b);
          end
          checks++;
          if (bad !== 0) begin
            failures++;
            $display("FAIL frame_timing: byte=%02h bad_cycles=%0d exp=0", exp_b, bad);
          end
        end
      end
    end
  end

  task automatic test_reset;
    reset_n = 1'b0; tx_enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got=%b exp=1", tx); end
    checks++; if (read_en !== 1'b0) begin failures++; $display("FAIL reset_read_en: got=%b exp=0", read_en); end
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got=%b exp=0", tx_busy); end
    checks++; if (tx_done !== 1'b0) begin failures++; $display("FAIL reset_done: got=%b exp=0", tx_done); end
  endtask

  task automatic test_single_frame;
    int r0, d0, b0;
    fifo_q.push_back(8'hA5); exp_q.push_back(8'hA5); tx_enable = 1'b1;
    repeat (2) @(negedge clk);
    r0 = rd_cnt; d0 = done_cnt; b0 = busy_cnt;
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (read_en !== 1'b0) begin failures++; $display("FAIL release_edge1_read_en: got=%b exp=0", read_en); end
    @(posedge clk); #1;
    checks++; if (read_en !== 1'b1) begin failures++; $display("FAIL release_edge2_read_en: got=%b exp=1", read_en); end
    for (int i = 0; i < 300 && done_cnt < d0 + 1; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++; if (rd_cnt - r0 !== 1) begin failures++; $display("FAIL single_read_en: got=%0d exp=1", rd_cnt - r0); end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL single_done: got=%0d exp=1", done_cnt - d0); end
    checks++; if (busy_cnt - b0 !== 2 + NB * CPB) begin failures++; $display("FAIL single_busy: got=%0d exp=%0d", busy_cnt - b0, 2 + NB * CPB); end
  endtask

  task automatic test_back_to_back;
    int r0, d0;
    @(negedge clk);
    r0 = rd_cnt; d0 = done_cnt; gap_q.delete();
    foreach (fifo_q[i]) ;
    fifo_q.push_back(8'h01); fifo_q.push_back(8'h80); fifo_q.push_back(8'hFF);
    exp_q.push_back(8'h01); exp_q.push_back(8'h80); exp_q.push_back(8'hFF);
    for (int i = 0; i < 800 && done_cnt < d0 + 3; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++; if (rd_cnt - r0 !== 3) begin failures++; $display("FAIL b2b_read_en: got=%0d exp=3", rd_cnt - r0); end
    checks++; if (done_cnt - d0 !== 3) begin failures++; $display("FAIL b2b_done: got=%0d exp=3", done_cnt - d0); end
    checks++;
    if (gap_q.size() !== 3 || gap_q[1] !== 3 || gap_q[2] !== 3) begin
      failures++;
      $display("FAIL b2b_gap: frames=%0d gaps=%0d,%0d exp=3 frames gaps 3,3", gap_q.size(),
               gap_q.size() > 1 ? gap_q[1] : -1, gap_q.size() > 2 ? gap_q[2] : -1);
    end
  endtask

  task automatic test_empty;
    int r0, b0, l0;
    tx_enable = 1'b1;
    @(negedge clk);
    r0 = rd_cnt; b0 = busy_cnt; l0 = low_cnt;
    repeat (100) @(negedge clk);
    checks++; if (rd_cnt - r0 !== 0) begin failures++; $display("FAIL empty_read_en: got=%0d exp=0", rd_cnt - r0); end
    checks++; if (busy_cnt - b0 !== 0) begin failures++; $display("FAIL empty_busy: got=%0d exp=0", busy_cnt - b0); end
    checks++; if (low_cnt - l0 !== 0) begin failures++; $display("FAIL empty_tx_low: got=%0d exp=0", low_cnt - l0); end
  endtask

  task automatic test_enable_gate;
    int r0, d0;
    @(negedge clk);
    tx_enable = 1'b0; r0 = rd_cnt; d0 = done_cnt;
    fifo_q.push_back(8'h11); fifo_q.push_back(8'h22);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    repeat (20) @(negedge clk);
    checks++; if (rd_cnt - r0 !== 0) begin failures++; $display("FAIL gate_disabled_read_en: got=%0d exp=0", rd_cnt - r0); end
    tx_enable = 1'b1;
    for (int i = 0; i < 20 && rd_cnt == r0; i++) @(negedge clk);
    tx_enable = 1'b0;
    for (int i = 0; i < 300 && done_cnt < d0 + 1; i++) @(negedge clk);
    repeat (60) @(negedge clk);
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL gate_midframe_done: got=%0d exp=1", done_cnt - d0); end
    checks++; if (rd_cnt - r0 !== 1) begin failures++; $display("FAIL gate_midframe_read_en: got=%0d exp=1", rd_cnt - r0); end
    tx_enable = 1'b1;
    for (int i = 0; i < 300 && done_cnt < d0 + 2; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++; if (done_cnt - d0 !== 2) begin failures++; $display("FAIL gate_resume_done: got=%0d exp=2", done_cnt - d0); end
  endtask

  task automatic test_reset_mid;
    int r0, d0;
    @(negedge clk);
    r0 = rd_cnt; d0 = done_cnt;
    fifo_q.push_back(8'h3C); fifo_q.push_back(8'h5A);
    exp_q.push_back(8'h3C); exp_q.push_back(8'h5A);
    for (int i = 0; i < 50 && tx !== 1'b0; i++) @(negedge clk);
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL midreset_tx: got=%b exp=1", tx); end
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got=%b exp=0", tx_busy); end
    repeat (2) @(negedge clk);
    checks++; if (done_cnt - d0 !== 0) begin failures++; $display("FAIL midreset_done: got=%0d exp=0", done_cnt - d0); end
    reset_n = 1'b1;
    for (int i = 0; i < 300 && done_cnt < d0 + 1; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL midreset_next_done: got=%0d exp=1", done_cnt - d0); end
    checks++; if (rd_cnt - r0 !== 2) begin failures++; $display("FAIL midreset_read_en: got=%0d exp=2", rd_cnt - r0); end
  endtask

  task automatic test_wait_timeout;
    int r0, d0, b0, l0;
    @(negedge clk);
    hold_dv = 1'b1; r0 = rd_cnt; d0 = done_cnt; b0 = busy_cnt; l0 = low_cnt;
    fifo_q.push_back(8'h77);
    for (int i = 0; i < 20 && rd_cnt == r0; i++) @(negedge clk);
    repeat (12) @(negedge clk);
    hold_dv = 1'b0;
    checks++; if (rd_cnt - r0 !== 1) begin failures++; $display("FAIL timeout_read_en: got=%0d exp=1", rd_cnt - r0); end
    checks++; if (busy_cnt - b0 !== 5) begin failures++; $display("FAIL timeout_busy: got=%0d exp=5", busy_cnt - b0); end
    checks++; if (done_cnt - d0 !== 0) begin failures++; $display("FAIL timeout_done: got=%0d exp=0", done_cnt - d0); end
    checks++; if (low_cnt - l0 !== 0) begin failures++; $display("FAIL timeout_tx_low: got=%0d exp=0", low_cnt - l0); end
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL timeout_idle: got=%b exp=0", tx_busy); end
  endtask

  task automatic test_parity_frames;
    int d0, b0;
    @(negedge clk);
    d0 = done_cnt; b0 = busy_cnt;
    fifo_q.push_back(8'h07); fifo_q.push_back(8'h03);
    exp_q.push_back(8'h07); exp_q.push_back(8'h03);
    for (int i = 0; i < 400 && done_cnt < d0 + 2; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++; if (done_cnt - d0 !== 2) begin failures++; $display("FAIL parity_done: got=%0d exp=2", done_cnt - d0); end
    checks++; if (busy_cnt - b0 !== 2 * (2 + NB * CPB)) begin failures++; $display("FAIL parity_busy: got=%0d exp=%0d", busy_cnt - b0, 2 * (2 + NB * CPB)); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL scoreboard_drain: left=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_empty;
    test_enable_gate;
    test_reset_mid;
    test_wait_timeout;
    test_parity_frames;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
